// File: rtl/pc_ctrl.sv
// pc_ctrl: program counter with jump/flush/stall control, misalign flag and perf counters
module pc_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  input  logic        bus_hold_i,
  output logic [31:0] pc_o,
  output logic        flush_o,
  output logic        hold_o,
  output logic        misalign_o,
  output logic [31:0] jump_cnt_o,
  output logic [31:0] stall_cnt_o
);
  typedef enum logic {RUN, FLUSH} state_t;
  localparam logic [2:0] FRELOAD = 3'(FLUSH_CYCLES - 1);
  state_t      state_q, state_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic [31:0] pc_q, pc_d, jcnt_q, jcnt_d, scnt_q, scnt_d;
  logic        mis_q, mis_d;
  assign hold_o      = rst_n & (hold_flag_i | bus_hold_i) & ~jump_en_i;
  assign flush_o     = rst_n & (jump_en_i | (state_q == FLUSH));
  assign pc_o        = pc_q;
  assign misalign_o  = mis_q;
  assign jump_cnt_o  = jcnt_q;
  assign stall_cnt_o = scnt_q;
  // Flush sequencing: a jump (re)starts the extra flush cycles, which count down even while held
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (jump_en_i) begin
      state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      fcnt_d  = FRELOAD;
    end else if (state_q == FLUSH) begin
      fcnt_d  = fcnt_q - 3'd1;
      state_d = (fcnt_q == 3'd1) ? RUN : FLUSH;
    end
  end
  // Next PC (jump > hold > increment), sticky misalign and saturating counters
  always_comb begin
    pc_d   = jump_en_i ? {jump_addr_i[31:2], 2'b00} : hold_o ? pc_q : pc_q + 32'd4;
    mis_d  = mis_q | (jump_en_i & (|jump_addr_i[1:0]));
    jcnt_d = (jump_en_i && jcnt_q != '1) ? jcnt_q + 32'd1 : jcnt_q;
    scnt_d = (hold_o && scnt_q != '1) ? scnt_q + 32'd1 : scnt_q;
  end
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      pc_q    <= RESET_PC;
      mis_q   <= 1'b0;
      jcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
      jcnt_q  <= jcnt_d;
      scnt_q  <= scnt_d;
    end
  end
endmodule
